// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch front end that sits in front of decode. It owns
//            the fetch PC and drives the address of a combinational imem. Each
//            fetched word is stored with its PC in a small circular queue.
//            The queue head is presented to decode with a valid flag. Fetch
//            keeps running while decode stalls. Branch/jump redirects flush
//            the queue and restart fetch at the target.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous, active-low reset
//            pc_F         - fetch address (drives imem address)
//            imem_rd      - imem word for pc_F (combinational return)
//            stall_F      - hold fetch: no push, pc_F held
//            stall_D      - decode not accepting: no pop
//            redirect_en  - flush the queue and refetch from redirect_pc
//            redirect_pc  - redirect target
//            instr_D      - head instruction, NOP_INSTR when empty
//            pc_D         - head PC, 0 when empty
//            pcplus4_D    - head PC + 4, 0 when empty
//            valid_D      - queue non-empty
//            fifo_count   - number of occupied entries
//            misalign_err - one-cycle pulse, last redirect target unaligned
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                pc_F,
    input  logic [31:0]                imem_rd,
    input  logic                       stall_F,
    input  logic                       stall_D,
    input  logic                       redirect_en,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                instr_D,
    output logic [31:0]                pc_D,
    output logic [31:0]                pcplus4_D,
    output logic                       valid_D,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    // Queue storage. Entries are not reset: an entry is only visible
    // after it has been written, and empty-state outputs are forced.
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];

    logic [31:0]   r_pc_f;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_misalign;

    logic          w_valid;
    logic          w_push;
    logic          w_pop;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ~stall_D;
    // A full queue refuses the push even when the head pops this cycle;
    // at count=1 push and pop still overlap for full throughput.
    assign w_push  = ~stall_F & (r_count < c_depth);

    // Control state: PC, pointers, occupancy, misalign pulse.
    // Redirect wins over push/pop/stall; the imem word this cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc_f     <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else if (redirect_en) begin
            r_pc_f     <= {redirect_pc[31:2], 2'b00};
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_misalign <= |redirect_pc[1:0];
        end else begin
            r_misalign <= 1'b0;
            if (w_push) begin
                r_pc_f <= r_pc_f + 32'd4;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Data write path, gated by the same conditions that advance r_wptr.
    always_ff @(posedge clk) begin
        if (reset && !redirect_en && w_push) begin
            r_pc_mem[r_wptr]    <= r_pc_f;
            r_instr_mem[r_wptr] <= imem_rd;
        end
    end

    assign pc_F         = r_pc_f;
    assign valid_D      = w_valid;
    assign fifo_count   = r_count;
    assign misalign_err = r_misalign;
    assign instr_D      = w_valid ? r_instr_mem[r_rptr] : NOP_INSTR;
    assign pc_D         = w_valid ? r_pc_mem[r_rptr] : 32'd0;
    assign pcplus4_D    = w_valid ? (r_pc_mem[r_rptr] + 32'd4) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue (DEPTH=2). The imem
//            is modelled as imem_rd = pc_F | 32'hA000_0000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [31:0]   pc_F;
    logic [31:0]   imem_rd;
    logic          stall_F;
    logic          stall_D;
    logic          redirect_en;
    logic [31:0]   redirect_pc;
    logic [31:0]   instr_D;
    logic [31:0]   pc_D;
    logic [31:0]   pcplus4_D;
    logic          valid_D;
    logic [CW-1:0] fifo_count;
    logic          misalign_err;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue #(
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_F         (pc_F),
        .imem_rd      (imem_rd),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .instr_D      (instr_D),
        .pc_D         (pc_D),
        .pcplus4_D    (pcplus4_D),
        .valid_D      (valid_D),
        .fifo_count   (fifo_count),
        .misalign_err (misalign_err)
    );

    assign imem_rd = pc_F | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall_F = 1'b0; stall_D = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'd0;
        step(); step();
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL reset_valid got %h exp 0", valid_D); end
        n_cmp++; if (instr_D !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr got %h exp 00000013", instr_D); end
        n_cmp++; if (pc_D !== 32'd0) begin n_err++; $display("FAIL reset_pc_D got %h exp 0", pc_D); end
        n_cmp++; if (pcplus4_D !== 32'd0) begin n_err++; $display("FAIL reset_pcplus4 got %h exp 0", pcplus4_D); end
        n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        n_cmp++; if (pc_F !== 32'd0) begin n_err++; $display("FAIL reset_pc_F got %h exp 0", pc_F); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %h exp 0", misalign_err); end
    endtask

    task automatic test_startup();
        reset = 1'b1;
        step();
        n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL start_valid got %h exp 1", valid_D); end
        n_cmp++; if (pc_D !== 32'd0) begin n_err++; $display("FAIL start_pc_D got %h exp 0", pc_D); end
        n_cmp++; if (instr_D !== 32'hA000_0000) begin n_err++; $display("FAIL start_instr got %h exp a0000000", instr_D); end
        n_cmp++; if (pcplus4_D !== 32'd4) begin n_err++; $display("FAIL start_pcplus4 got %h exp 4", pcplus4_D); end
        n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL start_count got %0d exp 1", fifo_count); end
        n_cmp++; if (pc_F !== 32'd4) begin n_err++; $display("FAIL start_pc_F got %h exp 4", pc_F); end
        step();
        n_cmp++; if (pc_D !== 32'd4) begin n_err++; $display("FAIL steady_pc_D got %h exp 4", pc_D); end
        n_cmp++; if (instr_D !== 32'hA000_0004) begin n_err++; $display("FAIL steady_instr got %h exp a0000004", instr_D); end
        n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL steady_count got %0d exp 1", fifo_count); end
        n_cmp++; if (pc_F !== 32'd8) begin n_err++; $display("FAIL steady_pc_F got %h exp 8", pc_F); end
    endtask

    task automatic test_stall_d();
        stall_D = 1'b1;
        step();
        n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL stallD_count got %0d exp 2", fifo_count); end
        n_cmp++; if (pc_F !== 32'd12) begin n_err++; $display("FAIL stallD_pc_F got %h exp c", pc_F); end
        step(); step(); step();
        n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL stallD_hold_count got %0d exp 2", fifo_count); end
        n_cmp++; if (pc_F !== 32'd12) begin n_err++; $display("FAIL stallD_hold_pc_F got %h exp c", pc_F); end
        n_cmp++; if (pc_D !== 32'd4) begin n_err++; $display("FAIL stallD_hold_pc_D got %h exp 4", pc_D); end
        stall_D = 1'b0;
        step();
        n_cmp++; if (pc_D !== 32'd8) begin n_err++; $display("FAIL drain1_pc_D got %h exp 8", pc_D); end
        n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL drain1_count got %0d exp 1", fifo_count); end
        n_cmp++; if (pc_F !== 32'd12) begin n_err++; $display("FAIL drain1_pc_F got %h exp c", pc_F); end
        step();
        n_cmp++; if (pc_D !== 32'd12) begin n_err++; $display("FAIL drain2_pc_D got %h exp c", pc_D); end
        n_cmp++; if (instr_D !== 32'hA000_000C) begin n_err++; $display("FAIL drain2_instr got %h exp a000000c", instr_D); end
        n_cmp++; if (pc_F !== 32'd16) begin n_err++; $display("FAIL drain2_pc_F got %h exp 10", pc_F); end
        step();
        n_cmp++; if (pc_D !== 32'd16) begin n_err++; $display("FAIL drain3_pc_D got %h exp 10", pc_D); end
    endtask

    task automatic test_redirect();
        // pc_D=16, pc_F=20, count=1: fill to 2 first
        stall_D = 1'b1;
        step();
        n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL redir_fill_count got %0d exp 2", fifo_count); end
        stall_D = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL redir_valid got %h exp 0", valid_D); end
        n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL redir_count got %0d exp 0", fifo_count); end
        n_cmp++; if (pc_F !== 32'h100) begin n_err++; $display("FAIL redir_pc_F got %h exp 100", pc_F); end
        n_cmp++; if (instr_D !== 32'h0000_0013) begin n_err++; $display("FAIL redir_instr got %h exp 00000013", instr_D); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL redir_misalign got %h exp 0", misalign_err); end
        redirect_en = 1'b0;
        step();
        n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL redir2_valid got %h exp 1", valid_D); end
        n_cmp++; if (pc_D !== 32'h100) begin n_err++; $display("FAIL redir2_pc_D got %h exp 100", pc_D); end
        n_cmp++; if (pcplus4_D !== 32'h104) begin n_err++; $display("FAIL redir2_pcplus4 got %h exp 104", pcplus4_D); end
        n_cmp++; if (instr_D !== 32'hA000_0100) begin n_err++; $display("FAIL redir2_instr got %h exp a0000100", instr_D); end
        n_cmp++; if (pc_F !== 32'h104) begin n_err++; $display("FAIL redir2_pc_F got %h exp 104", pc_F); end
    endtask

    task automatic test_misalign();
        redirect_en = 1'b1; redirect_pc = 32'h0000_0203;
        step();
        n_cmp++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %h exp 1", misalign_err); end
        n_cmp++; if (pc_F !== 32'h200) begin n_err++; $display("FAIL mis_pc_F got %h exp 200", pc_F); end
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL mis_valid got %h exp 0", valid_D); end
        redirect_en = 1'b0;
        step();
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear got %h exp 0", misalign_err); end
        n_cmp++; if (pc_D !== 32'h200) begin n_err++; $display("FAIL mis_pc_D got %h exp 200", pc_D); end
        redirect_en = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_aligned got %h exp 0", misalign_err); end
        n_cmp++; if (pc_F !== 32'h300) begin n_err++; $display("FAIL mis_aligned_pc_F got %h exp 300", pc_F); end
        redirect_en = 1'b0;
        step();
        n_cmp++; if (pc_D !== 32'h300) begin n_err++; $display("FAIL mis_after_pc_D got %h exp 300", pc_D); end
    endtask

    task automatic test_redirect_stall_f();
        redirect_en = 1'b1; redirect_pc = 32'h0000_0400; stall_F = 1'b1; stall_D = 1'b0;
        step();
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL rsf_valid got %h exp 0", valid_D); end
        n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL rsf_count got %0d exp 0", fifo_count); end
        n_cmp++; if (pc_F !== 32'h400) begin n_err++; $display("FAIL rsf_pc_F got %h exp 400", pc_F); end
        redirect_en = 1'b0;
        step(); step();
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL rsf_hold_valid got %h exp 0", valid_D); end
        n_cmp++; if (pc_F !== 32'h400) begin n_err++; $display("FAIL rsf_hold_pc_F got %h exp 400", pc_F); end
        stall_F = 1'b0;
        step();
        n_cmp++; if (valid_D !== 1'b1) begin n_err++; $display("FAIL rsf_rel_valid got %h exp 1", valid_D); end
        n_cmp++; if (pc_D !== 32'h400) begin n_err++; $display("FAIL rsf_rel_pc_D got %h exp 400", pc_D); end
    endtask

    task automatic test_both_stall();
        // pc_D=0x400, count=1, pc_F=0x404
        stall_F = 1'b1; stall_D = 1'b1;
        step(); step();
        n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL frz_count got %0d exp 1", fifo_count); end
        n_cmp++; if (pc_F !== 32'h404) begin n_err++; $display("FAIL frz_pc_F got %h exp 404", pc_F); end
        n_cmp++; if (pc_D !== 32'h400) begin n_err++; $display("FAIL frz_pc_D got %h exp 400", pc_D); end
        stall_D = 1'b0;
        step();
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL sF_drain_valid got %h exp 0", valid_D); end
        n_cmp++; if (pc_F !== 32'h404) begin n_err++; $display("FAIL sF_drain_pc_F got %h exp 404", pc_F); end
        stall_F = 1'b0;
        step();
        n_cmp++; if (pc_D !== 32'h404) begin n_err++; $display("FAIL sF_resume_pc_D got %h exp 404", pc_D); end
        n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL sF_resume_count got %0d exp 1", fifo_count); end
    endtask

    task automatic test_reset_midstream();
        stall_D = 1'b1;
        step();
        n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL rst_mid_fill got %0d exp 2", fifo_count); end
        reset = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h0000_0203;
        step();
        n_cmp++; if (pc_F !== 32'd0) begin n_err++; $display("FAIL rst_mid_pc_F got %h exp 0", pc_F); end
        n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL rst_mid_count got %0d exp 0", fifo_count); end
        n_cmp++; if (valid_D !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %h exp 0", valid_D); end
        n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_misalign got %h exp 0", misalign_err); end
        reset = 1'b1; redirect_en = 1'b0; stall_D = 1'b0;
        step();
        n_cmp++; if (pc_D !== 32'd0 || valid_D !== 1'b1) begin n_err++; $display("FAIL rst_mid_restart got pc_D=%h valid=%h exp 0/1", pc_D, valid_D); end
    endtask

    task automatic test_pc_wrap();
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        n_cmp++; if (pc_F !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc_F got %h exp fffffffc", pc_F); end
        redirect_en = 1'b0;
        step();
        n_cmp++; if (pc_D !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc_D got %h exp fffffffc", pc_D); end
        n_cmp++; if (pcplus4_D !== 32'd0) begin n_err++; $display("FAIL wrap_pcplus4 got %h exp 0", pcplus4_D); end
        n_cmp++; if (pc_F !== 32'd0) begin n_err++; $display("FAIL wrap_pc_F_next got %h exp 0", pc_F); end
        step();
        n_cmp++; if (pc_D !== 32'd0) begin n_err++; $display("FAIL wrap_pc_D_next got %h exp 0", pc_D); end
        n_cmp++; if (instr_D !== 32'hA000_0000) begin n_err++; $display("FAIL wrap_instr got %h exp a0000000", instr_D); end
    endtask

    initial begin
        reset = 1'b0; stall_F = 1'b0; stall_D = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'd0;
        #1;
        test_reset();
        test_startup();
        test_stall_d();
        test_redirect();
        test_misalign();
        test_redirect_stall_f();
        test_both_stall();
        test_reset_midstream();
        test_pc_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
